// File: rtl/tiny16_pkg.sv
// Shared types and default parameters for the tiny16 run controller.
package tiny16_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StReset,
        StRun,
        StFinish
    } state_e;

    localparam int unsigned DefDataW     = 8;
    localparam int unsigned DefCycW      = 16;
    localparam int unsigned DefRstCycles = 2;
    localparam int unsigned DefMaxCycles = 255;

endpackage

// File: rtl/tiny16_run_ctrl_if.sv
// Control/status bundle between a test harness and the tiny16 run controller.
interface tiny16_run_ctrl_if
    import tiny16_pkg::*;
#(
    parameter int unsigned DATA_W = DefDataW,
    parameter int unsigned CYC_W  = DefCycW
);
    logic              START;
    logic              HALT;
    logic [DATA_W-1:0] OUT_IN;
    logic [DATA_W-1:0] EXPECT;
    logic              CPU_RST;
    logic              RUNNING;
    logic              DONE;
    logic              PASS;
    logic              TIMEOUT;
    logic [CYC_W-1:0]  CYCLES;
    logic [DATA_W-1:0] RESULT;

    modport master (
        output START, HALT, OUT_IN, EXPECT,
        input  CPU_RST, RUNNING, DONE, PASS, TIMEOUT, CYCLES, RESULT
    );

    modport slave (
        input  START, HALT, OUT_IN, EXPECT,
        output CPU_RST, RUNNING, DONE, PASS, TIMEOUT, CYCLES, RESULT
    );
endinterface

// File: rtl/tiny16_run_ctrl.sv
// Sequences a tiny16 CPU through reset and a bounded run, then latches its verdict.
module tiny16_run_ctrl
    import tiny16_pkg::*;
#(
    parameter int unsigned DATA_W     = DefDataW,
    parameter int unsigned CYC_W      = DefCycW,
    parameter int unsigned RST_CYCLES = DefRstCycles,
    parameter int unsigned MAX_CYCLES = DefMaxCycles
) (
    input logic              CLK,
    input logic              RST,
    tiny16_run_ctrl_if.slave bus
);

    localparam logic [7:0]       RstLast = 8'(RST_CYCLES - 1);
    localparam logic [CYC_W-1:0] MaxCnt  = CYC_W'(MAX_CYCLES);

    state_e            state_q, state_d;
    logic [7:0]        rst_cnt_q, rst_cnt_d;
    logic [CYC_W-1:0]  cycles_q, cycles_d, cycles_inc;
    logic [DATA_W-1:0] result_q, result_d;
    logic              pass_q, pass_d;
    logic              timeout_q, timeout_d;
    logic              cpu_rst_q, cpu_rst_d;
    logic              running_q, running_d;
    logic              done_q, done_d;
    logic              begin_run;

    always_comb begin
        state_d    = state_q;
        rst_cnt_d  = rst_cnt_q;
        cycles_d   = cycles_q;
        result_d   = result_q;
        pass_d     = pass_q;
        timeout_d  = timeout_q;
        begin_run  = 1'b0;
        cycles_inc = cycles_q + CYC_W'(1);

        unique case (state_q)
            StIdle: begin
                if (bus.START) begin_run = 1'b1;
            end
            StReset: begin
                if (rst_cnt_q == RstLast) begin
                    state_d   = StRun;
                    rst_cnt_d = 8'd0;
                end else begin
                    rst_cnt_d = rst_cnt_q + 8'd1;
                end
            end
            StRun: begin
                cycles_d = cycles_inc;
                // Halt wins over budget exhaustion in the same cycle.
                if (bus.HALT) begin
                    state_d   = StFinish;
                    result_d  = bus.OUT_IN;
                    pass_d    = (bus.OUT_IN == bus.EXPECT);
                    timeout_d = 1'b0;
                end else if (cycles_inc == MaxCnt) begin
                    state_d   = StFinish;
                    result_d  = bus.OUT_IN;
                    pass_d    = 1'b0;
                    timeout_d = 1'b1;
                end
            end
            StFinish: begin
                if (bus.START) begin_run = 1'b1;
            end
            default: state_d = StIdle;
        endcase

        if (begin_run) begin
            state_d   = StReset;
            rst_cnt_d = 8'd0;
            cycles_d  = '0;
            result_d  = '0;
            pass_d    = 1'b0;
            timeout_d = 1'b0;
        end

        // Status flags are registered copies of the next state.
        cpu_rst_d = (state_d != StRun);
        running_d = (state_d == StRun);
        done_d    = (state_d == StFinish);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= StIdle;
            rst_cnt_q <= 8'd0;
            cycles_q  <= '0;
            result_q  <= '0;
            pass_q    <= 1'b0;
            timeout_q <= 1'b0;
            cpu_rst_q <= 1'b1;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rst_cnt_q <= rst_cnt_d;
            cycles_q  <= cycles_d;
            result_q  <= result_d;
            pass_q    <= pass_d;
            timeout_q <= timeout_d;
            cpu_rst_q <= cpu_rst_d;
            running_q <= running_d;
            done_q    <= done_d;
        end
    end

    assign bus.CPU_RST = cpu_rst_q;
    assign bus.RUNNING = running_q;
    assign bus.DONE    = done_q;
    assign bus.PASS    = pass_q;
    assign bus.TIMEOUT = timeout_q;
    assign bus.CYCLES  = cycles_q;
    assign bus.RESULT  = result_q;

endmodule
